// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
//   Shared definitions for the host-to-pet command path:
//   - receiver and parser state encodings (exposed for debug/checker binding)
//   - CMD_* action codes consumed by the game-logic block
//   - ASCII constants used by the line parser
//   - letter_to_code: maps a command letter (either case) to its action code,
//     returning CMD_NONE when the byte is not a command letter.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_ARG,
    P_DISCARD
  } p_state_e;

  localparam logic [2:0] CMD_NONE     = 3'd0;
  localparam logic [2:0] CMD_FEED     = 3'd1;
  localparam logic [2:0] CMD_PLAY     = 3'd2;
  localparam logic [2:0] CMD_CLEAN    = 3'd3;
  localparam logic [2:0] CMD_SLEEP    = 3'd4;
  localparam logic [2:0] CMD_WAKE     = 3'd5;
  localparam logic [2:0] CMD_MEDICINE = 3'd6;
  localparam logic [2:0] CMD_STATUS   = 3'd7;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;

  function automatic logic [2:0] letter_to_code(input logic [7:0] ch);
    logic [7:0] up;
    up = ch;
    // fold 'a'..'z' onto 'A'..'Z'
    if (ch >= 8'h61 && ch <= 8'h7A) up = ch - 8'h20;
    case (up)
      8'h46:   letter_to_code = CMD_FEED;     // F
      8'h50:   letter_to_code = CMD_PLAY;     // P
      8'h43:   letter_to_code = CMD_CLEAN;    // C
      8'h53:   letter_to_code = CMD_SLEEP;    // S
      8'h57:   letter_to_code = CMD_WAKE;     // W
      8'h4D:   letter_to_code = CMD_MEDICINE; // M
      8'h52:   letter_to_code = CMD_STATUS;   // R
      default: letter_to_code = CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   8N1 UART receiver with a 2-FF input synchroniser.
//   Ports:
//     clk, rst_n     : clock, async active-low reset
//     uart_rx        : serial line, idle high, asynchronous to clk
//     rx_byte        : last byte received with a good stop bit
//     rx_byte_valid  : 1-cycle pulse, rx_byte updated in the same cycle
//     frame_err      : 1-cycle pulse on a low stop bit (byte discarded)
//     state          : receiver FSM state, for debug and busy reporting
//   Pulse outputs have no back-pressure: a consumer must act on the cycle
//   the pulse is high; nothing is held for it.
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int DELAY_FRAMES = 234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err,
  output rx_state_e  state
);

  localparam int CW = $clog2(DELAY_FRAMES + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DELAY_FRAMES / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(DELAY_FRAMES - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // synchroniser powers up as "line idle" so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], uart_rx};
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RX_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          // re-check at mid start bit; a high level here was only a glitch
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};  // LSB first
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_byte       <= shreg;
              rx_byte_valid <= 1'b1;
              state         <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_BREAK: begin
          // line held low (break or desync): wait for idle before re-arming
          if (rx_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
//   Host command receiver: UART bytes are parsed into short ASCII lines
//   "<letter>[digits]<CR|LF>" and turned into action pulses.
//   Ports:
//     clk, rst_n     : 27 MHz clock, async active-low reset
//     uart_rx        : serial line from the host terminal
//     rx_byte        : last good received byte
//     rx_byte_valid  : 1-cycle pulse per good byte
//     frame_err      : 1-cycle pulse on a bad stop bit
//     cmd_valid      : 1-cycle pulse when a line is accepted
//     cmd_code       : action code (1..7), held until the next cmd_valid
//     cmd_arg        : argument 0..15 (1 when omitted), held with cmd_code
//     cmd_err        : 1-cycle pulse when a line is rejected
//     busy           : receiver mid-frame or parser holding a partial line
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int DELAY_FRAMES = 234,
  parameter int CMD_TIMEOUT  = 2700000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [4:0] cmd_arg,
  output logic       cmd_err,
  output logic       busy
);

  localparam int TW = $clog2(CMD_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(CMD_TIMEOUT - 1);

  rx_state_e     rx_state;
  p_state_e      p_state;
  logic [2:0]    code_q;
  logic [4:0]    arg_acc;
  logic [1:0]    ndig;
  logic          bad;
  logic [TW-1:0] to_cnt;

  logic [2:0]    code_hit;
  logic          is_term;
  logic          is_space;
  logic          is_digit;
  logic [3:0]    digit;
  logic [8:0]    mac;
  logic [8:0]    digit_val;
  logic          digit_bad;

  uart_rx_core #(
    .DELAY_FRAMES(DELAY_FRAMES)
  ) u_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx       (uart_rx),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .frame_err     (frame_err),
    .state         (rx_state)
  );

  // byte classification and argument arithmetic; the 9-bit product holds
  // 31*10+9, so any carry out of the 5-bit argument shows up in digit_val
  always_comb begin
    code_hit  = letter_to_code(rx_byte);
    is_term   = (rx_byte == ASCII_CR) || (rx_byte == ASCII_LF);
    is_space  = (rx_byte == ASCII_SPACE);
    is_digit  = (rx_byte >= ASCII_0) && (rx_byte <= ASCII_9);
    digit     = rx_byte[3:0];
    mac       = {4'b0, arg_acc} * 9'd10 + {5'b0, digit};
    digit_val = (ndig == 2'd0) ? {5'b0, digit} : mac;
    digit_bad = (ndig == 2'd2) || (digit_val > 9'd15);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state   <= P_IDLE;
      code_q    <= CMD_NONE;
      arg_acc   <= '0;
      ndig      <= '0;
      bad       <= 1'b0;
      to_cnt    <= '0;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_code  <= '0;
      cmd_arg   <= '0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      case (p_state)
        P_IDLE: begin
          to_cnt <= '0;
          if (rx_byte_valid) begin
            if (code_hit != CMD_NONE) begin
              code_q  <= code_hit;
              arg_acc <= 5'd1;
              ndig    <= '0;
              bad     <= 1'b0;
              p_state <= P_ARG;
            end else if (!is_term && !is_space) begin
              p_state <= P_DISCARD;
            end
          end
        end
        P_ARG, P_DISCARD: begin
          if (rx_byte_valid) begin
            to_cnt <= '0;
            if (is_term) begin
              if (p_state == P_ARG && !bad) begin
                cmd_valid <= 1'b1;
                cmd_code  <= code_q;
                cmd_arg   <= arg_acc;
              end else begin
                cmd_err <= 1'b1;
              end
              p_state <= P_IDLE;
            end else if (p_state == P_ARG && is_digit) begin
              arg_acc <= digit_val[4:0];
              if (digit_bad) bad <= 1'b1;
              if (ndig != 2'd2) ndig <= ndig + 1'b1;
            end else begin
              p_state <= P_DISCARD;
            end
          end else if (frame_err) begin
            // a corrupted byte means the line can no longer be trusted
            p_state <= P_DISCARD;
            to_cnt  <= '0;
          end else if (to_cnt == TO_LAST) begin
            // stale partial line: drop it quietly
            p_state <= P_IDLE;
            to_cnt  <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: p_state <= P_IDLE;
      endcase
    end
  end

  assign busy = (rx_state != RX_IDLE) || (p_state != P_IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
module tb_uart_cmd_rx;

  localparam int DF = 64;
  localparam int TO = 3000;

  logic       clk;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       frame_err;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [4:0] cmd_arg;
  logic       cmd_err;
  logic       busy;

  uart_cmd_rx #(
    .DELAY_FRAMES(DF),
    .CMD_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx       (uart_rx),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .frame_err     (frame_err),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .cmd_arg       (cmd_arg),
    .cmd_err       (cmd_err),
    .busy          (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard ----------------
  int compared = 0;
  int mism     = 0;
  int cyc      = 0;
  int last_rbv = -100;
  int rx_extra = 0;
  int cmd_extra = 0;
  int fe_cnt   = 0;
  int exp_fe   = 0;
  int model_code = 0;
  int model_arg  = 0;

  logic [7:0] exp_rx_q[$];
  logic [9:0] exp_q[$];      // {err, valid, code[2:0], arg[4:0]}
  logic [7:0] line_q[$];
  string      letters = "FPCSWMR";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (line level) ----------------
  task automatic model_line_end();
    int i;
    int code;
    int n;
    int val;
    bit err;
    i = 0; code = 0; n = 0; val = 0; err = 0;
    while (i < line_q.size() && line_q[i] == 8'h20) i++;
    if (i == line_q.size()) return;
    for (int k = 0; k < 7; k++) begin
      logic [7:0] l;
      l = letters[k];
      if (line_q[i] == l || line_q[i] == l + 8'h20) code = k + 1;
    end
    if (code == 0) err = 1;
    for (int j = i + 1; j < line_q.size(); j++) begin
      if (line_q[j] >= 8'h30 && line_q[j] <= 8'h39) begin
        n++;
        if (n <= 2) val = val * 10 + int'(line_q[j]) - 48;
      end else begin
        err = 1;
      end
    end
    if (n == 0) val = 1;
    if (n > 2 || val > 15) err = 1;
    if (err) exp_q.push_back({2'b10, 8'd0});
    else begin
      exp_q.push_back({2'b01, 3'(code), 5'(val)});
      model_code = code;
      model_arg  = val;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_rx_q.push_back(b);
    if (b == 8'h0D || b == 8'h0A) begin
      model_line_end();
      line_q.delete();
    end else begin
      line_q.push_back(b);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [9:0] obs;
    cyc++;
    if (rx_byte_valid) begin
      if (exp_rx_q.size() == 0) rx_extra++;
      else check("rx_byte", rx_byte, exp_rx_q.pop_front());
      last_rbv = cyc;
    end
    if (cmd_valid || cmd_err) begin
      check("cmd_latency", cyc - last_rbv, 1);
      obs = {cmd_err, cmd_valid, cmd_valid ? cmd_code : 3'd0, cmd_valid ? cmd_arg : 5'd0};
      if (exp_q.size() == 0) cmd_extra++;
      else check("cmd_event", obs, exp_q.pop_front());
    end
    if (frame_err) fe_cnt++;
  end

  // ---------------- drivers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    wait_cycles(DF);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cycles(DF);
    end
    uart_rx = stop_bit;
    wait_cycles(DF);
  endtask

  task automatic send_q(input logic [7:0] bq[$]);
    foreach (bq[i]) begin
      model_byte(bq[i]);
      send_frame(bq[i], 1'b1);
      wait_cycles($urandom_range(0, 15));
    end
  endtask

  task automatic send_str(input string s);
    logic [7:0] bq[$];
    for (int i = 0; i < s.len(); i++) bq.push_back(s[i]);
    send_q(bq);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {rx_byte, rx_byte_valid, frame_err, cmd_valid, cmd_code, cmd_arg, cmd_err, busy}, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    wait_cycles(5);
    check_zero("reset_outputs");
    rst_n = 1'b1;
    wait_cycles(10);

    // F3<CR>
    send_str("F3\r");
    wait_cycles(20);
    check("f3_pending", exp_q.size(), 0);
    check("f3_code", cmd_code, 1);
    check("f3_arg", cmd_arg, 3);

    // s<CR><LF>: only one pulse
    send_str("s\r\n");
    wait_cycles(20);
    check("s_pending", exp_q.size(), 0);
    check("s_code", cmd_code, 4);
    check("s_arg", cmd_arg, 1);

    // two rejected lines, held code/arg unchanged
    send_str("P16\r");
    send_str("X\r");
    wait_cycles(20);
    check("err_pending", exp_q.size(), 0);
    check("err_hold_code", cmd_code, 4);
    check("err_hold_arg", cmd_arg, 1);

    // bad stop bit, line held low 3 bit-times
    send_frame(8'h46, 1'b0);
    exp_fe++;
    wait_cycles(3 * DF);
    uart_rx = 1'b1;
    wait_cycles(DF);
    check("frame_err_count", fe_cnt, exp_fe);
    send_str("C\r");
    wait_cycles(20);
    check("c_code", cmd_code, 3);
    check("c_arg", cmd_arg, 1);

    // partial line timeout
    send_str("M1");
    check("busy_partial", busy, 1);
    wait_cycles(TO + 10);
    check("busy_timeout", busy, 0);
    line_q.delete();
    send_str("\r");
    wait_cycles(20);
    check("to_pending", exp_q.size(), 0);
    check("to_hold_code", cmd_code, 3);

    // reset in the middle of a data bit of 'W'
    uart_rx = 1'b0;
    wait_cycles(DF);
    for (int i = 0; i < 3; i++) begin
      uart_rx = (i == 2) ? 1'b1 : 1'b1;
      wait_cycles(DF);
    end
    uart_rx = 1'b0;
    wait_cycles(DF / 2);
    rst_n = 1'b0;
    wait_cycles(2);
    check_zero("midframe_reset");
    line_q.delete();
    model_code = 0;
    model_arg  = 0;
    uart_rx = 1'b1;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(DF);
    send_str("W\r");
    wait_cycles(20);
    check("w_code", cmd_code, 5);
    check("w_arg", cmd_arg, 1);

    // short glitch on idle line
    uart_rx = 1'b0;
    wait_cycles(20);
    uart_rx = 1'b1;
    wait_cycles(4 * DF);
    check("glitch_busy", busy, 0);
    check("glitch_fe", fe_cnt, exp_fe);
    check("glitch_rx_extra", rx_extra, 0);

    // random command lines
    for (int ln = 0; ln < 10; ln++) begin
      logic [7:0] bq[$];
      logic [7:0] ch;
      int r;
      int nd;
      if ($urandom_range(0, 4) == 0) bq.push_back(8'h20);
      r = $urandom_range(0, 9);
      if (r < 8) begin
        ch = letters[$urandom_range(0, 6)];
        if ($urandom_range(0, 1) == 1) ch = ch + 8'h20;
      end else begin
        ch = (r == 8) ? 8'h58 : 8'h37;
      end
      bq.push_back(ch);
      if ($urandom_range(0, 7) == 0) bq.push_back(8'h20);
      nd = $urandom_range(0, 3);
      for (int d = 0; d < nd; d++)
        bq.push_back(8'(48 + ((d == 0 && nd == 2) ? $urandom_range(0, 1) : $urandom_range(0, 9))));
      r = $urandom_range(0, 2);
      if (r == 0) bq.push_back(8'h0D);
      else if (r == 1) bq.push_back(8'h0A);
      else begin
        bq.push_back(8'h0D);
        bq.push_back(8'h0A);
      end
      send_q(bq);
      wait_cycles(20);
      check("rand_code", cmd_code, model_code);
      check("rand_arg", cmd_arg, model_arg);
    end

    wait_cycles(50);
    check("final_rx_pending", exp_rx_q.size(), 0);
    check("final_cmd_pending", exp_q.size(), 0);
    check("final_rx_extra", rx_extra, 0);
    check("final_cmd_extra", cmd_extra, 0);
    check("final_frame_err", fe_cnt, exp_fe);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
